// File: rtl/floo_eos_monitor.sv
// End-of-simulation monitor: latches per-core end_of_sim flags over a cluster grid and
// sequences IDLE -> RUN -> DRAIN -> DONE, with an optional RUN-cycle watchdog.
module floo_eos_monitor #(
   parameter int unsigned NumClusters   = 32,
   parameter int unsigned NumCores      = 9,
   parameter int unsigned DrainCycles   = 100,
   parameter int unsigned TimeoutCycles = 0,
   parameter int unsigned CntWidth      = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             en_i,
   input  logic                             clear_i,
   input  logic [NumClusters-1:0]           cluster_mask_i,
   input  logic [NumClusters*NumCores-1:0]  eos_i,
   output logic [NumClusters-1:0]           cluster_done_o,
   output logic [$clog2(NumClusters+1)-1:0] num_done_o,
   output logic                             all_done_o,
   output logic                             sim_end_o,
   output logic                             done_o,
   output logic                             timeout_o,
   output logic [CntWidth-1:0]              cycles_o,
   output logic [2:0]                       state_o
);

   localparam int unsigned NumW        = $clog2(NumClusters+1);
   localparam int unsigned DrainW      = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
   localparam int unsigned DrainLast   = (DrainCycles > 0) ? DrainCycles - 1 : 0;
   localparam int unsigned TimeoutLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      DRAIN   = 3'd2,
      DONE    = 3'd3,
      TIMEOUT = 3'd4
   } state_e;

   state_e                            state_q, state_d;
   logic [NumClusters-1:0]            mask_q, mask_d;
   logic [NumClusters*NumCores-1:0]   latch_q, latch_d;
   logic [NumClusters-1:0]            cdone_q, cdone_d;
   logic [CntWidth-1:0]               cycles_q, cycles_d;
   logic [DrainW-1:0]                 drain_q, drain_d;
   logic                              sim_end_q, sim_end_d;
   logic                              all_done;
   logic [NumW-1:0]                   num_done;

   // Gated by state so the zero mask held in IDLE does not read as complete.
   always_comb begin
      all_done = (state_q != IDLE);
      for (int c = 0; c < NumClusters; c++) begin
         if (mask_q[c] && !cdone_q[c]) all_done = 1'b0;
      end
   end

   always_comb begin
      num_done = '0;
      for (int c = 0; c < NumClusters; c++) begin
         num_done = num_done + NumW'(cdone_q[c]);
      end
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      latch_d  = latch_q;
      cycles_d = cycles_q;
      drain_d  = drain_q;
      cdone_d  = cdone_q;
      sim_end_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (en_i) begin
               mask_d   = cluster_mask_i;
               cycles_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            latch_d = latch_q | eos_i;
            if (all_done) begin
               drain_d = '0;
               state_d = (DrainCycles == 0) ? DONE : DRAIN;
            end else if ((TimeoutCycles != 0) && (cycles_q == CntWidth'(TimeoutLast))) begin
               state_d = TIMEOUT;
            end else if (cycles_q != '1) begin
               cycles_d = cycles_q + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_q == DrainW'(DrainLast)) state_d = DONE;
            else                                drain_d = drain_q + 1'b1;
         end
         default: ;
      endcase

      // Registered from the next latch value so completion shows one cycle after the last eos.
      for (int c = 0; c < NumClusters; c++) begin
         cdone_d[c] = mask_q[c] & (&latch_d[c*NumCores +: NumCores]);
      end

      sim_end_d = (state_d == DONE) && (state_q != DONE);

      if (clear_i) begin
         state_d   = IDLE;
         mask_d    = '0;
         latch_d   = '0;
         cycles_d  = '0;
         drain_d   = '0;
         cdone_d   = '0;
         sim_end_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         latch_q   <= '0;
         cycles_q  <= '0;
         drain_q   <= '0;
         cdone_q   <= '0;
         sim_end_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         latch_q   <= latch_d;
         cycles_q  <= cycles_d;
         drain_q   <= drain_d;
         cdone_q   <= cdone_d;
         sim_end_q <= sim_end_d;
      end
   end

   assign cluster_done_o = cdone_q;
   assign num_done_o     = num_done;
   assign all_done_o     = all_done;
   assign sim_end_o      = sim_end_q;
   assign done_o         = (state_q == DONE);
   assign timeout_o      = (state_q == TIMEOUT);
   assign cycles_o       = cycles_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_floo_eos_monitor.sv
// Bench for floo_eos_monitor: two instances (with watchdog / zero drain), randomized eos timing,
// expected termination events queued from a timing model and matched by a monitor.
module tb_floo_eos_monitor;

   localparam int NCA = 32, NKA = 9, DA = 100, TOA = 50;
   localparam int NCB = 4,  NKB = 3, DB = 0,   TOB = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic en_a, clr_a, en_b, clr_b;
   logic [NCA-1:0]     mask_a;
   logic [NCA*NKA-1:0] eos_a;
   logic [NCB-1:0]     mask_b;
   logic [NCB*NKB-1:0] eos_b;

   logic [NCA-1:0] cd_a;  logic [5:0] num_a;  logic ad_a, se_a, dn_a, to_a;
   logic [31:0] cyc_a;    logic [2:0] st_a;
   logic [NCB-1:0] cd_b;  logic [2:0] num_b;  logic ad_b, se_b, dn_b, to_b;
   logic [31:0] cyc_b;    logic [2:0] st_b;

   floo_eos_monitor #(.NumClusters(NCA), .NumCores(NKA), .DrainCycles(DA),
                      .TimeoutCycles(TOA), .CntWidth(32)) dut_a (
      .clk_i(clk), .rst_i(rst), .en_i(en_a), .clear_i(clr_a), .cluster_mask_i(mask_a),
      .eos_i(eos_a), .cluster_done_o(cd_a), .num_done_o(num_a), .all_done_o(ad_a),
      .sim_end_o(se_a), .done_o(dn_a), .timeout_o(to_a), .cycles_o(cyc_a), .state_o(st_a));

   floo_eos_monitor #(.NumClusters(NCB), .NumCores(NKB), .DrainCycles(DB),
                      .TimeoutCycles(TOB), .CntWidth(32)) dut_b (
      .clk_i(clk), .rst_i(rst), .en_i(en_b), .clear_i(clr_b), .cluster_mask_i(mask_b),
      .eos_i(eos_b), .cluster_done_o(cd_b), .num_done_o(num_b), .all_done_o(ad_b),
      .sim_end_o(se_b), .done_o(dn_b), .timeout_o(to_b), .cycles_o(cyc_b), .state_o(st_b));

   typedef struct {
      bit          which;
      bit          is_to;
      int          rel;
      int          cycles;
      logic [31:0] cdone;
   } exp_t;

   exp_t expq[$];
   int   n_chk = 0, n_fail = 0;
   int   cyc = 0, start_cyc = 0;
   int   tfirst[32][9];
   int   thold[32][9];
   bit   prev_to_a = 1'b0, prev_to_b = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic mon_event(input bit which);
      exp_t e;
      logic [31:0] cd;
      if (expq.size() == 0) begin
         check("unexpected_end_event", 1, 0);
         return;
      end
      e  = expq.pop_front();
      cd = which ? {28'b0, cd_b} : cd_a;
      check("event_instance", which, e.which);
      check("event_is_timeout", which ? to_b : to_a, e.is_to);
      check("event_rel_cycle", cyc - start_cyc, e.rel);
      check("event_cycles_o", which ? cyc_b : cyc_a, e.cycles);
      check("event_cluster_done", cd, e.cdone);
      check("event_num_done", which ? num_b : num_a, $countones(e.cdone));
      check("event_all_done", which ? ad_b : ad_a, !e.is_to);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (se_a || (to_a && !prev_to_a)) mon_event(1'b0);
         if (se_b || (to_b && !prev_to_b)) mon_event(1'b1);
      end
      prev_to_a = to_a;
      prev_to_b = to_b;
   end

   // Completion time model: a cluster finishes at the latest first-assertion of its cores.
   function automatic exp_t model(input bit which, input logic [31:0] mask);
      exp_t e;
      int nc = which ? NCB : NCA, nk = which ? NKB : NKA;
      int d  = which ? DB : DA,   to = which ? TOB : TOA;
      int a = 0, dt;
      bit never = 0, inc;
      logic [31:0] fin = '0;
      for (int c = 0; c < nc; c++) begin
         if (mask[c]) begin
            dt = -1; inc = 0;
            for (int k = 0; k < nk; k++) begin
               if (tfirst[c][k] < 0) inc = 1;
               else if (tfirst[c][k] > dt) dt = tfirst[c][k];
            end
            if (inc) never = 1;
            else begin
               fin[c] = 1'b1;
               if (dt + 1 > a) a = dt + 1;
            end
         end
      end
      e.which = which;
      e.cdone = fin;
      if (to != 0 && (never || a > to - 1)) begin
         e.is_to = 1; e.rel = to; e.cycles = to - 1;
      end else begin
         e.is_to = 0; e.rel = a + 1 + d; e.cycles = a;
      end
      return e;
   endfunction

   task automatic drive(input bit which, input int r);
      logic [NCA*NKA-1:0] v = '0;
      int nc = which ? NCB : NCA, nk = which ? NKB : NKA;
      for (int c = 0; c < nc; c++)
         for (int k = 0; k < nk; k++)
            if (tfirst[c][k] >= 0 && r >= tfirst[c][k] && r < tfirst[c][k] + thold[c][k])
               v[c*nk+k] = 1'b1;
      if (which) eos_b = v[NCB*NKB-1:0];
      else       eos_a = v;
   endtask

   task automatic set_times(input int lo, input int hi, input int never_pct);
      for (int c = 0; c < 32; c++)
         for (int k = 0; k < 9; k++) begin
            tfirst[c][k] = ($urandom_range(99, 0) < never_pct) ? -1 : int'($urandom_range(hi, lo));
            thold[c][k]  = int'($urandom_range(3, 1));
         end
   endtask

   task automatic run(input bit which, input logic [31:0] mask, input bit push, input int stop_rel);
      exp_t e = model(which, mask);
      int limit = push ? e.rel + 2 : stop_rel;
      if (push) expq.push_back(e);
      @(negedge clk);
      if (which) begin mask_b = mask[NCB-1:0]; en_b = 1; end
      else       begin mask_a = mask;          en_a = 1; end
      start_cyc = cyc + 1;
      @(negedge clk);
      en_a = 0; en_b = 0;
      for (int r = 0; r < limit; r++) begin
         drive(which, r);
         @(negedge clk);
      end
      eos_a = '0; eos_b = '0;
      if (push) begin
         check("pending_events", expq.size(), 0);
         expq.delete();
      end
   endtask

   task automatic check_idle(input bit which, input string tag);
      check({tag, "_state"},    which ? st_b  : st_a, 0);
      check({tag, "_cdone"},    which ? 32'(cd_b) : cd_a, 0);
      check({tag, "_num_done"}, which ? num_b : num_a, 0);
      check({tag, "_all_done"}, which ? ad_b  : ad_a, 0);
      check({tag, "_sim_end"},  which ? se_b  : se_a, 0);
      check({tag, "_done"},     which ? dn_b  : dn_a, 0);
      check({tag, "_timeout"},  which ? to_b  : to_a, 0);
      check({tag, "_cycles"},   which ? cyc_b : cyc_a, 0);
   endtask

   task automatic clear_and_check(input bit which);
      @(negedge clk);
      if (which) clr_b = 1; else clr_a = 1;
      @(negedge clk);
      clr_a = 0; clr_b = 0;
      check_idle(which, "after_clear");
   endtask

   initial begin
      exp_t e;
      rst = 1; en_a = 0; clr_a = 0; en_b = 0; clr_b = 0;
      mask_a = '0; mask_b = '0; eos_a = '0; eos_b = '0;
      repeat (3) @(negedge clk);
      check_idle(0, "reset_a");
      check_idle(1, "reset_b");
      rst = 0;

      // Every core of cluster c asserts at RUN cycle 10+c for one cycle.
      for (int c = 0; c < 32; c++)
         for (int k = 0; k < 9; k++) begin tfirst[c][k] = 10 + c; thold[c][k] = 1; end
      run(0, '1, 1, 0);
      clear_and_check(0);

      // Only clusters 0-3 enabled and asserting.
      set_times(0, 30, 0);
      for (int c = 4; c < 32; c++) for (int k = 0; k < 9; k++) tfirst[c][k] = -1;
      run(0, 32'h0000_000F, 1, 0);
      clear_and_check(0);

      // Cluster 5 never completes: watchdog fires.
      set_times(0, 40, 0);
      tfirst[5][4] = -1;
      run(0, '1, 1, 0);
      clear_and_check(0);

      // Completion lands exactly on the last watchdog cycle: completion wins.
      set_times(0, 40, 0);
      tfirst[7][0] = 48;
      run(0, '1, 1, 0);
      clear_and_check(0);

      for (int i = 0; i < 5; i++) begin
         set_times(0, 45, 2);
         run(0, $urandom, 1, 0);
         clear_and_check(0);
      end

      // Reset in the middle of DRAIN aborts without a sim_end pulse.
      set_times(0, 5, 0);
      e = model(0, '1);
      run(0, '1, 0, e.rel - 80);
      check("mid_drain_state", st_a, 2);
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      check_idle(0, "after_reset");
      eos_a = '1;
      repeat (5) @(negedge clk);
      check("idle_eos_state", st_a, 0);
      en_a = 1; mask_a = '1; eos_a = '0;
      @(negedge clk); en_a = 0;
      repeat (2) @(negedge clk);
      check("rearm_state", st_a, 1);
      check("rearm_no_latch_cdone", cd_a, 0);
      check("rearm_no_latch_num", num_a, 0);
      clear_and_check(0);

      // Zero drain, zero mask: one RUN cycle then DONE.
      for (int c = 0; c < 32; c++) for (int k = 0; k < 9; k++) tfirst[c][k] = -1;
      run(1, 32'h0, 1, 0);
      check("b_done_level", dn_b, 1);
      check("b_done_state", st_b, 3);
      check("b_sim_end_single", se_b, 0);
      clear_and_check(1);

      for (int i = 0; i < 3; i++) begin
         set_times(0, 20, 0);
         run(1, {28'b0, 4'($urandom)}, 1, 0);
         clear_and_check(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
